// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped UART transmitter with an 8-deep byte FIFO.
//
// Register window (16 bytes at BASE_ADDR, address bits [3:0] select the register):
//   0x0 TXDATA  W: push Bus_wdata[7:0] into the FIFO     R: 0
//   0x4 STATUS  R: {20'b0, count[3:0], 4'b0, ovr, empty, full, busy}
//               W: writing 1 to bit 3 clears the sticky overrun flag
//   0x8 DIV     R/W: 16-bit baud divisor (cpu_clk cycles per bit); 0 is stored as 1
//   0xC         reserved: reads 0, writes ignored
//
// Ports:
//   cpu_clk    single clock; all state changes on its rising edge
//   cpu_rst    synchronous reset, active low
//   Bus_addr   byte address from the CPU bridge
//   Bus_wen    write strobe
//   Bus_wdata  write data
//   Bus_rdata  combinational read data for the current Bus_addr (0 outside the window)
//   uart_txd   registered serial output, idle high
//
// Build option: define UART_PARITY_EN to insert an even-parity bit between the
// last data bit and the stop bit (11-bit frame instead of 10).
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F100,
  parameter logic [15:0] DEF_DIV   = 16'd217
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] Bus_addr,
  input  logic        Bus_wen,
  input  logic [31:0] Bus_wdata,
  output logic [31:0] Bus_rdata,
  output logic        uart_txd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // ---------------- register decode ----------------
  logic       sel;
  logic [1:0] off;
  logic       wr_tx, wr_st, wr_div;

  assign sel    = (Bus_addr[31:4] == BASE_ADDR[31:4]);
  assign off    = Bus_addr[3:2];
  assign wr_tx  = sel && Bus_wen && (off == 2'd0);
  assign wr_st  = sel && Bus_wen && (off == 2'd1);
  assign wr_div = sel && Bus_wen && (off == 2'd2);

  // Byte-lane bits of the address and the top half of write data are never decoded.
  logic unused_bits;
  assign unused_bits = ^{Bus_addr[1:0], Bus_wdata[31:16]};

  // ---------------- FIFO ----------------
  logic [7:0] mem_q [8];
  logic [2:0] wr_ptr_q, rd_ptr_q;
  logic [3:0] cnt_q;
  logic       ovr_q;
  logic       full, empty, push, pop;
  logic [7:0] head;

  assign full  = (cnt_q == 4'd8);
  assign empty = (cnt_q == 4'd0);
  assign head  = mem_q[rd_ptr_q];
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign push  = wr_tx && (!full || pop);

  always_ff @(posedge cpu_clk) begin
    if (push) mem_q[wr_ptr_q] <= Bus_wdata[7:0];
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 3'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 4'd1;
        2'b01:   cnt_q <= cnt_q - 4'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (wr_tx && full && !pop)          ovr_q <= 1'b1;
      else if (wr_st && Bus_wdata[3])     ovr_q <= 1'b0;
    end
  end

  // ---------------- divisor ----------------
  logic [15:0] div_q;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst)    div_q <= DEF_DIV;
    else if (wr_div) div_q <= (Bus_wdata[15:0] == 16'd0) ? 16'd1 : Bus_wdata[15:0];
  end

  // ---------------- transmit FSM ----------------
  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;   // cycles remaining in the current bit, minus one
  logic [2:0]  bit_q, bit_d;     // data bit index
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        bit_end;
`ifdef UART_PARITY_EN
  logic        par_q, par_d;
`endif

  assign bit_end = (baud_q == 16'd0);

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? div_q - 16'd1 : baud_q - 16'd1;  // reload picks up DIV at each bit start
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_PARITY_EN
          par_d   = ^head;
`endif
          bit_d   = '0;
          baud_d  = div_q - 16'd1;
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          txd_d   = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            txd_d   = par_q;
            state_d = S_PARITY;
`else
            txd_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          baud_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        txd_d   = 1'b1;
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign uart_txd = txd_q;

  // ---------------- read mux ----------------
  logic busy;
  assign busy = (state_q != S_IDLE) || !empty;

  always_comb begin
    Bus_rdata = '0;
    if (sel) begin
      case (off)
        2'd1:    Bus_rdata = {20'b0, cnt_q, 4'b0, ovr_q, empty, full, busy};
        2'd2:    Bus_rdata = {16'b0, div_q};
        default: Bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// tb_bus_uart_tx: directed plus randomized bench for bus_uart_tx. Expected line
// waveforms are built from the frame definition (start, 8 data bits LSB first,
// optional even parity, stop) with per-bit durations.
module tb_bus_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_F100;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [31:0] Bus_addr = '0;
  logic        Bus_wen = 1'b0;
  logic [31:0] Bus_wdata = '0;
  logic [31:0] Bus_rdata;
  logic        uart_txd;

  int checks = 0;
  int failures = 0;

  bus_uart_tx #(.BASE_ADDR(BASE), .DEF_DIV(16'd217)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .Bus_addr (Bus_addr),
    .Bus_wen  (Bus_wen),
    .Bus_wdata(Bus_wdata),
    .Bus_rdata(Bus_rdata),
    .uart_txd (uart_txd)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st_word(input int cnt, input bit ovr, input bit busy);
    logic [3:0] c;
    c = cnt[3:0];
    return {20'b0, c, 4'b0, ovr, (cnt == 0), (cnt == 8), busy};
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge cpu_clk);
    Bus_addr = a; Bus_wdata = d; Bus_wen = 1'b1;
    @(posedge cpu_clk);
    #1 Bus_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Bus_addr = a;
    #1 d = Bus_rdata;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (uart_txd !== 1'b0 && n < budget) begin
      @(negedge cpu_clk);
      n++;
    end
    chk("start_bit_seen", {31'b0, uart_txd}, 32'h0);
  endtask

  // Caller is positioned at the negedge of the first start-bit cycle.
  // Start bit lasts div0 cycles, every later bit div1 cycles; with do_wr the
  // DIV=div1 write is issued during the first start cycle.
  task automatic check_frame(input logic [7:0] d, input int div0, input int div1, input bit do_wr);
    logic bits[$];
    int   dur;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++) begin
      dur = (i == 0) ? div0 : div1;
      for (int c = 0; c < dur; c++) begin
        if (!(i == 0 && c == 0)) begin
          @(posedge cpu_clk);
          #1 Bus_wen = 1'b0;
          @(negedge cpu_clk);
        end
        chk($sformatf("txd d=%02h bit%0d cyc%0d", d, i, c), {31'b0, uart_txd}, {31'b0, bits[i]});
        if (do_wr && i == 0 && c == 0) begin
          Bus_addr = A_DV; Bus_wdata = div1; Bus_wen = 1'b1;
        end
      end
    end
    @(negedge cpu_clk);
    chk("txd idle gap", {31'b0, uart_txd}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          dv, n;
    bit          low_seen;

    // ---- reset state ----
    repeat (3) @(posedge cpu_clk);
    #1;
    chk("txd in reset", {31'b0, uart_txd}, 32'h1);
    cpu_rst = 1'b1;
    bus_read(A_ST, rd); chk("status after reset", rd, st_word(0, 0, 0));
    bus_read(A_DV, rd); chk("div after reset", rd, 32'h0000_00D9);
    bus_read(BASE + 32'h10, rd); chk("outside window", rd, 32'h0);
    bus_read(A_TX, rd); chk("txdata reads 0", rd, 32'h0);

    // ---- reserved offset ----
    bus_write(A_RS, 32'h1234_5678);
    bus_read(A_RS, rd); chk("reserved reads 0", rd, 32'h0);
    bus_read(A_DV, rd); chk("div after reserved write", rd, 32'h0000_00D9);

    // ---- latency and 0xA5 frame at DIV=4 ----
    bus_write(A_DV, 32'd4);
    bus_write(A_TX, 32'hA5);
    @(negedge cpu_clk);
    chk("txd one edge after write", {31'b0, uart_txd}, 32'h1);
    @(negedge cpu_clk);
    check_frame(8'hA5, 4, 4, 1'b0);
    bus_read(A_ST, rd); chk("status idle after frame", rd, st_word(0, 0, 0));

    // ---- DIV change mid start bit ----
    b = 8'($urandom);
    bus_write(A_TX, {24'b0, b});
    wait_start(8);
    check_frame(b, 4, 2, 1'b1);
    bus_read(A_DV, rd); chk("div after mid-bit write", rd, 32'd2);

    // ---- DIV=0 stored as 1 ----
    bus_write(A_DV, 32'd0);
    bus_read(A_DV, rd); chk("div zero -> 1", rd, 32'd1);
    b = 8'($urandom);
    bus_write(A_TX, {24'b0, b});
    wait_start(8);
    check_frame(b, 1, 1, 1'b0);

    // ---- randomized frames ----
    for (int k = 0; k < 6; k++) begin
      dv = $urandom_range(1, 6);
      b  = 8'($urandom);
      bus_write(A_DV, dv);
      bus_read(A_DV, rd); chk($sformatf("div readback %0d", k), rd, dv);
      bus_write(A_TX, {24'b0, b});
      wait_start(8);
      check_frame(b, dv, dv, 1'b0);
    end

    // ---- FIFO fill, overrun, clear ----
    bus_write(A_DV, 32'd1);
    for (int k = 0; k < 9; k++) bus_write(A_TX, k);
    bus_read(A_ST, rd); chk("status after 9 writes", rd, st_word(8, 0, 1));
    bus_write(A_TX, 32'h09);
    bus_read(A_ST, rd); chk("status after overrun", rd, st_word(8, 1, 1));
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, rd); chk("status after ovr clear", rd, st_word(8, 0, 1));
    // byte 0 is already on the line; pick up at the pop of byte 1
    n = 0;
    do begin
      @(negedge cpu_clk);
      bus_read(A_ST, rd);
      n++;
    end while (rd[11:8] != 4'd7 && n < 40);
    chk("count drops to 7", {28'b0, rd[11:8]}, 32'd7);
    check_frame(8'h01, 1, 1, 1'b0);
    for (int k = 2; k < 9; k++) begin
      wait_start(4);
      check_frame(k[7:0], 1, 1, 1'b0);
    end
    low_seen = 1'b0;
    repeat (30) begin
      @(negedge cpu_clk);
      if (uart_txd !== 1'b1) low_seen = 1'b1;
    end
    chk("dropped byte never sent", {31'b0, low_seen}, 32'h0);
    bus_read(A_ST, rd); chk("status drained", rd, st_word(0, 0, 0));

    // ---- reset mid-frame ----
    bus_write(A_DV, 32'd8);
    bus_write(A_TX, 32'hFF);
    wait_start(8);
    repeat (3 * 8 + 3) @(negedge cpu_clk);
    chk("txd high in data bit", {31'b0, uart_txd}, 32'h1);
    bus_read(A_ST, rd); chk("busy before reset", rd, st_word(0, 0, 1));
    cpu_rst = 1'b0;
    @(posedge cpu_clk);
    #1 cpu_rst = 1'b1;
    chk("txd after mid-frame reset", {31'b0, uart_txd}, 32'h1);
    bus_read(A_ST, rd); chk("status after mid-frame reset", rd, st_word(0, 0, 0));
    bus_read(A_DV, rd); chk("div after mid-frame reset", rd, 32'h0000_00D9);
    low_seen = 1'b0;
    repeat (300) begin
      @(negedge cpu_clk);
      if (uart_txd !== 1'b1) low_seen = 1'b1;
    end
    chk("no start after reset", {31'b0, low_seen}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
